regfile_alu_pipe: RTL and testbench

//  Parametrised successor to the 16x16 regfile/mux/ALU/flags datapath. Adds a registered
//  EX stage with a valid/ready issue handshake, a write-back bypass and a multi-cycle

---
 rtl/regfile_alu_pipe.sv | 194 +++++++++++++++++++
 tb/tb_regfile_alu_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_pipe.sv
// Register file with a registered EX stage, write-back bypass and a shift-add multiplier.
// One instruction issues per cycle through a valid/ready handshake; MUL holds issue for DATA_W cycles.
module regfile_alu_pipe #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_code,
    input  logic [SEL_W-1:0]  a_sel,
    input  logic [SEL_W-1:0]  b_sel,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] immediate,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic              wb_valid,
    output logic [SEL_W-1:0]  wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        flags
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int MSB   = DATA_W - 1;
    localparam int FN = 4, FC = 3, FF = 2, FZ = 1, FL = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_ADDC = 4'd1, OP_SUB = 4'd2, OP_CMP = 4'd3,
        OP_AND  = 4'd4,  OP_OR   = 4'd5, OP_XOR = 4'd6, OP_MOV = 4'd7,
        OP_LSH  = 4'd8,  OP_RSH  = 4'd9, OP_MUL = 4'd10
    } op_e;

    // Returns {flags_out, result}. For OP_MUL the finished product is passed in as a.
    function automatic logic [DATA_W+4:0] alu_f(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [4:0] fl);
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] r;
        logic [4:0]        f;
        sum = '0;
        r   = '0;
        f   = fl;
        case (op)
            OP_ADD:  sum = {1'b0, a} + {1'b0, b};
            OP_ADDC: sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, fl[FC]};
            OP_SUB, OP_CMP: sum = {1'b0, a} - {1'b0, b};
            default: sum = '0;
        endcase
        case (op)
            OP_ADD, OP_ADDC: begin
                r     = sum[MSB:0];
                f[FC] = sum[DATA_W];
                f[FF] = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                r     = sum[MSB:0];
                f[FC] = sum[DATA_W];
                f[FL] = sum[DATA_W];
                f[FF] = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MOV:  r = b;
            OP_LSH:  r = a << b[SH_W-1:0];
            OP_RSH:  r = a >> b[SH_W-1:0];
            OP_MUL:  r = a;
            default: r = '0;
        endcase
        if (op <= OP_MUL) begin
            f[FZ] = (r == '0);
            f[FN] = r[MSB];
        end
        return {f, r};
    endfunction

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              vld_p1;
    logic [3:0]        op_p1;
    logic [DATA_W-1:0] a_p1, b_p1;
    logic [SEL_W-1:0]  dst_p1;
    logic              wr_p1;

    logic              mul_busy;
    logic [CNT_W-1:0]  mul_cnt;
    logic [DATA_W-1:0] mul_a, mul_b, mul_acc;
    logic [SEL_W-1:0]  mul_dst;
    logic              mul_wr;

    logic              issue, mul_done;
    logic [DATA_W-1:0] mul_acc_nxt;
    logic              ret_vld, ret_wr;
    logic [SEL_W-1:0]  ret_dst;
    logic [DATA_W-1:0] ret_data;
    logic [4:0]        ret_flags;
    logic [DATA_W-1:0] opa, regb, opb;

    assign in_ready    = !reset && !mul_busy;
    assign issue       = in_valid && in_ready;
    assign dbg_data    = regs[dbg_sel];
    assign mul_done    = mul_busy && (mul_cnt == CNT_W'(DATA_W - 1));
    assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);

    // Retirement: at most one of the EX op or the finishing multiply retires on an edge.
    always_comb begin
        ret_vld   = 1'b0;
        ret_wr    = 1'b0;
        ret_dst   = '0;
        ret_data  = '0;
        ret_flags = flags;
        if (vld_p1) begin
            ret_vld               = 1'b1;
            ret_wr                = wr_p1;
            ret_dst               = dst_p1;
            {ret_flags, ret_data} = alu_f(op_p1, a_p1, b_p1, flags);
        end else if (mul_done) begin
            ret_vld               = 1'b1;
            ret_wr                = mul_wr;
            ret_dst               = mul_dst;
            {ret_flags, ret_data} = alu_f(OP_MUL, mul_acc_nxt, '0, flags);
        end
    end

    // Operand fetch with bypass of the result being written on this same edge.
    assign opa  = (ret_wr && ret_dst == a_sel) ? ret_data : regs[a_sel];
    assign regb = (ret_wr && ret_dst == b_sel) ? ret_data : regs[b_sel];
    assign opb  = use_imm ? immediate : regb;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flags    <= '0;
            vld_p1   <= 1'b0;
            op_p1    <= '0;
            a_p1     <= '0;
            b_p1     <= '0;
            dst_p1   <= '0;
            wr_p1    <= 1'b0;
            mul_busy <= 1'b0;
            mul_cnt  <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_acc  <= '0;
            mul_dst  <= '0;
            mul_wr   <= 1'b0;
            wb_valid <= 1'b0;
            wb_dst   <= '0;
            wb_data  <= '0;
        end else begin
            // Issue -> EX stage
            vld_p1 <= issue && (op_code != OP_MUL);
            if (issue) begin
                op_p1  <= op_code;
                a_p1   <= opa;
                b_p1   <= opb;
                dst_p1 <= a_sel;
                wr_p1  <= wr_en && (op_code != OP_CMP) && (op_code <= OP_MUL);
            end

            // Multiplier: one shift-add step per cycle while busy
            if (issue && op_code == OP_MUL) begin
                mul_busy <= 1'b1;
                mul_cnt  <= '0;
                mul_a    <= opa;
                mul_b    <= opb;
                mul_acc  <= '0;
                mul_dst  <= a_sel;
                mul_wr   <= wr_en;
            end else if (mul_busy) begin
                mul_acc <= mul_acc_nxt;
                mul_a   <= mul_a << 1;
                mul_b   <= mul_b >> 1;
                mul_cnt <= mul_cnt + CNT_W'(1);
                if (mul_done) mul_busy <= 1'b0;
            end

            // Write-back stage
            wb_valid <= ret_vld;
            if (ret_vld) begin
                flags   <= ret_flags;
                wb_dst  <= ret_dst;
                wb_data <= ret_data;
                if (ret_wr) regs[ret_dst] <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe: a 16x16 instance and an 8x8 instance
// exercised with hand-computed instruction sequences.
module tb_regfile_alu_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, use_imm = 1'b0, wr_en = 1'b0, wb_valid;
    logic [3:0]  op_code = '0, a_sel = '0, b_sel = '0, dbg_sel = '0, wb_dst;
    logic [15:0] immediate = '0, dbg_data, wb_data;
    logic [4:0]  flags;

    logic        in_valid_8 = 1'b0, in_ready_8, use_imm_8 = 1'b0, wr_en_8 = 1'b0, wb_valid_8;
    logic [3:0]  op_code_8 = '0;
    logic [2:0]  a_sel_8 = '0, b_sel_8 = '0, dbg_sel_8 = '0, wb_dst_8;
    logic [7:0]  immediate_8 = '0, dbg_data_8, wb_data_8;
    logic [4:0]  flags_8;

    int checks = 0;
    int failures = 0;

    regfile_alu_pipe #(.DATA_W(16), .NUM_REGS(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .a_sel(a_sel), .b_sel(b_sel), .use_imm(use_imm),
        .immediate(immediate), .wr_en(wr_en), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .flags(flags)
    );

    regfile_alu_pipe #(.DATA_W(8), .NUM_REGS(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .op_code(op_code_8), .a_sel(a_sel_8), .b_sel(b_sel_8), .use_imm(use_imm_8),
        .immediate(immediate_8), .wr_en(wr_en_8), .dbg_sel(dbg_sel_8), .dbg_data(dbg_data_8),
        .wb_valid(wb_valid_8), .wb_dst(wb_dst_8), .wb_data(wb_data_8), .flags(flags_8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic ui, input logic [15:0] imm, input logic we);
        in_valid = 1'b1; op_code = op; a_sel = a; b_sel = b;
        use_imm = ui; immediate = imm; wr_en = we;
        tick();
        in_valid = 1'b0; wr_en = 1'b0;
    endtask

    task automatic iss8(input logic [3:0] op, input logic [2:0] a, input logic ui,
                        input logic [7:0] imm, input logic we);
        in_valid_8 = 1'b1; op_code_8 = op; a_sel_8 = a; b_sel_8 = '0;
        use_imm_8 = ui; immediate_8 = imm; wr_en_8 = we;
        tick();
        in_valid_8 = 1'b0; wr_en_8 = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] sel, input logic [15:0] exp);
        dbg_sel = sel;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic rd8(input string tag, input logic [2:0] sel, input logic [7:0] exp);
        dbg_sel_8 = sel;
        #1;
        check(tag, dbg_data_8, exp);
    endtask

    int low_cnt;
    int pulses;

    initial begin
        tick();
        tick();
        check("rst_ready", in_ready, 0);
        check("rst_flags", flags, 0);
        check("rst_wb_valid", wb_valid, 0);
        rd("rst_r3", 4'd3, 16'h0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);

        // MOV r3,#0x1234
        iss(4'd7, 4'd3, 4'd0, 1'b1, 16'h1234, 1'b1);
        tick();
        check("mov_wb_valid", wb_valid, 1);
        check("mov_wb_dst", wb_dst, 3);
        check("mov_wb_data", wb_data, 16'h1234);
        check("mov_flags", flags, 5'b00000);
        rd("mov_r3", 4'd3, 16'h1234);
        tick();
        check("mov_wb_pulse", wb_valid, 0);

        // MOV r1,#FFFF ; ADD r1,#1 ; ADDC r2,#0 back-to-back
        iss(4'd7, 4'd1, 4'd0, 1'b1, 16'hFFFF, 1'b1);
        iss(4'd0, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b1);
        iss(4'd1, 4'd2, 4'd0, 1'b1, 16'h0000, 1'b1);
        check("add_flags_cz", flags, 5'b01010);
        check("add_wb_data", wb_data, 16'h0);
        tick();
        rd("add_r1", 4'd1, 16'h0);
        rd("addc_r2", 4'd2, 16'h1);
        check("addc_flags", flags, 5'b00000);

        // MOV r4,#5 ; ADD r4,r4 via bypass
        iss(4'd7, 4'd4, 4'd0, 1'b1, 16'h0005, 1'b1);
        iss(4'd0, 4'd4, 4'd4, 1'b0, 16'h0000, 1'b1);
        tick();
        check("byp_wb_data", wb_data, 16'd10);
        rd("byp_r4", 4'd4, 16'd10);

        // MOV r5,#8000 ; SUB r5,#1
        iss(4'd7, 4'd5, 4'd0, 1'b1, 16'h8000, 1'b1);
        iss(4'd2, 4'd5, 4'd0, 1'b1, 16'h0001, 1'b1);
        tick();
        rd("sub_r5", 4'd5, 16'h7FFF);
        check("sub_flags", flags, 5'b00100);

        // MOV r6,#3 ; CMP r6,#7 with wr_en set
        iss(4'd7, 4'd6, 4'd0, 1'b1, 16'h0003, 1'b1);
        iss(4'd3, 4'd6, 4'd0, 1'b1, 16'h0007, 1'b1);
        tick();
        check("cmp_wb_valid", wb_valid, 1);
        check("cmp_flags", flags, 5'b11001);
        rd("cmp_r6", 4'd6, 16'h0003);

        // NOP on r3 with wr_en set
        iss(4'd12, 4'd3, 4'd0, 1'b1, 16'hBEEF, 1'b1);
        tick();
        check("nop_wb_valid", wb_valid, 1);
        check("nop_flags", flags, 5'b11001);
        rd("nop_r3", 4'd3, 16'h1234);

        // MOV r7,#0x0123 ; MUL r7,#0x0010
        iss(4'd7, 4'd7, 4'd0, 1'b1, 16'h0123, 1'b1);
        iss(4'd10, 4'd7, 4'd0, 1'b1, 16'h0010, 1'b1);
        low_cnt = 0;
        while (!in_ready && low_cnt < 40) begin
            low_cnt++;
            tick();
        end
        check("mul_busy_cycles", low_cnt, 16);
        check("mul_wb_valid", wb_valid, 1);
        check("mul_wb_data", wb_data, 16'h1230);
        check("mul_flags", flags, 5'b01001);
        rd("mul_r7", 4'd7, 16'h1230);
        tick();
        check("mul_wb_pulse", wb_valid, 0);

        // Second MUL aborted by reset on its fifth cycle
        iss(4'd10, 4'd7, 4'd0, 1'b1, 16'h0003, 1'b1);
        check("mul2_busy", in_ready, 0);
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("abort_ready_in_rst", in_ready, 0);
        reset = 1'b0;
        #1;
        check("abort_ready_after", in_ready, 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (wb_valid) pulses++;
            tick();
        end
        check("abort_no_wb", pulses, 0);
        rd("abort_r7", 4'd7, 16'h0);

        // 8-bit / 8-register instance
        iss8(4'd7, 3'd1, 1'b1, 8'hF0, 1'b1);
        iss8(4'd0, 3'd1, 1'b1, 8'h20, 1'b1);
        tick();
        rd8("w8_add_r1", 3'd1, 8'h10);
        check("w8_add_flags", flags_8, 5'b01000);
        iss8(4'd7, 3'd2, 1'b1, 8'h01, 1'b1);
        iss8(4'd8, 3'd2, 1'b1, 8'h07, 1'b1);
        tick();
        rd8("w8_lsh_r2", 3'd2, 8'h80);
        check("w8_lsh_flags", flags_8, 5'b11000);
        check("w8_wb_dst", wb_dst_8, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
